mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported unified memory between the pipelined core's fetch
//   stage (PCF/InstrF side) and its memory stage (ALUResultM/WriteDataM/ReadDataM
//   side). Handles variable-latency req/ack on the memory side and returns
//   per-requester stalls to the hazard logic. Data has priority; a starvation
//   counter guarantees fetch progress. A timeout aborts hung accesses with an error.
// PARAMETERS
//   AW            32   address width
//   DW            32   data width
//   STARVE_LIMIT  4    consecutive data grants with fetch pending before fetch wins (>=1)
//   TIMEOUT       255  busy cycles without mem_ack before abort (>=1)
// PORTS
//   clk          in   1   clock, all state on rising edge
//   reset        in   1   asynchronous, active-low reset (reset==0 clears all state)
//   if_req       in   1   fetch request, held with if_addr until if_valid
//   if_addr      in   AW  fetch address
//   if_rdata     out  DW  fetched instruction, valid while if_valid
//   if_valid     out  1   one-cycle completion pulse for fetch
//   d_req        in   1   data request, held with d_we/d_addr/d_wdata until d_valid
//   d_we         in   1   1=store, 0=load
//   d_addr       in   AW  data address
//   d_wdata      in   DW  store data
//   d_rdata      out  DW  load data, valid while d_valid (0 for stores)
//   d_valid      out  1   one-cycle completion pulse for data
//   err          out  1   one-cycle pulse, coincident with the valid of an aborted access
//   stall_f      out  1   if_req & ~if_valid (combinational)
//   stall_m      out  1   d_req & ~d_valid (combinational)
//   mem_req      out  1   memory request, held until mem_ack or abort
//   mem_we       out  1   memory write enable
//   mem_addr     out  AW  memory address
//   mem_wdata    out  DW  memory write data
//   mem_rdata    in   DW  memory read data, sampled in the mem_ack cycle
//   mem_ack      in   1   memory completion, one cycle
// BEHAVIOUR
//   - FSM states: IDLE, BUSY_I, BUSY_D. mem_req=1 only in BUSY_*; mem_we/addr/wdata
//     are driven from registered copies latched on the grant edge.
//   - Grant (evaluated in IDLE, or on the completing edge of a BUSY state): d_req only
//     -> BUSY_D; if_req only -> BUSY_I; both -> BUSY_D unless starve_cnt==STARVE_LIMIT,
//     in which case BUSY_I.
//   - On the completing edge, the requester just served is excluded from arbitration,
//     because its req is still high during the valid cycle. If the other requester is
//     pending, it is granted back-to-back; otherwise the FSM returns to IDLE.
//   - starve_cnt: +1 on every data grant made while if_req=1 (saturates at STARVE_LIMIT);
//     cleared on every fetch grant.
//   - Completion: at the edge where mem_ack=1 in BUSY_x, x_valid is pulsed for the next
//     cycle. x_rdata takes mem_rdata for loads/fetches and 0 for stores.
//   - Minimum latency: req seen at edge N -> mem_req from N; ack in the same cycle ->
//     valid in cycle N+1.
//   - Timeout: wait_cnt clears on grant and counts BUSY cycles without ack. When
//     wait_cnt==TIMEOUT: drop mem_req, pulse x_valid and err, and set x_rdata=0.
//     mem_ack is ignored in IDLE, so a late ack is discarded.
//   - Reset (any time, including mid-access): FSM=IDLE, mem_req=0, mem_we=0,
//     mem_addr/mem_wdata=0, *_valid=0, *_rdata=0, err=0, starve_cnt=0, wait_cnt=0.
//     The memory must tolerate an abandoned request.
//   - Requesters must not change address/data while req=1 and valid=0. Dropping req
//     mid-access is illegal; the arbiter still completes the access.
// TESTING
//   1 fetch only, if_addr=0x100, ack 1 cycle after mem_req, mem_rdata=0x00500093
//     -> if_valid 1 cycle, if_rdata=0x00500093, stall_f high until then
//   2 d_req store (0x2000, 0xDEADBEEF) and if_req together -> data granted first,
//     mem_we=1, d_rdata=0; fetch granted back-to-back on the completing edge
//   3 d_req held continuously with if_req pending -> fetch granted after exactly
//     4 data grants, then starve_cnt=0
//   4 no mem_ack for 255 busy cycles -> mem_req drops, d_valid+err pulse, d_rdata=0;
//     a later ack in IDLE has no effect
//   5 reset low while BUSY_D -> outputs zero immediately (asynchronously); after
//     release, the held d_req is re-granted and completes normally
//   6 zero-wait ack (mem_ack same cycle as mem_req) for alternating I/D streams
//     -> one completion every cycle, no lost or duplicated valid

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the fetch stage and the
//   memory stage of the pipelined core. Data accesses have priority. A
//   starvation counter lets fetch win once enough data grants have gone by
//   while fetch was waiting. A timeout aborts a memory access that never
//   acknowledges and reports it with err.
//
// Ports
//   clk, reset        clock (rising edge) and asynchronous active-low reset
//   if_req/if_addr    fetch request; if_rdata/if_valid return the instruction
//   d_req/d_we/d_addr/d_wdata   data request; d_rdata/d_valid return load data
//   err               pulses together with the valid of an aborted access
//   stall_f, stall_m  per-requester stalls to the hazard unit
//   mem_*             variable-latency memory port (req held until ack or abort)
//   dbgState          FSM state (0 idle, 1 fetch busy, 2 data busy)
//   dbgStarveCnt      current starvation count
//
// Handshake
//   A requester raises x_req with its address/data and holds them stable
//   until it sees x_valid, a single-cycle pulse. Its req is still high during
//   the valid cycle. It may then drop req or present a new request. On the
//   memory side, mem_req and the mem_we/mem_addr/mem_wdata fields stay
//   constant until the cycle in which mem_ack=1. mem_rdata is sampled in that
//   cycle. If the access is aborted, mem_req is withdrawn without an ack.

module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              if_req,
  input  logic [AW-1:0]                     if_addr,
  output logic [DW-1:0]                     if_rdata,
  output logic                              if_valid,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [AW-1:0]                     d_addr,
  input  logic [DW-1:0]                     d_wdata,
  output logic [DW-1:0]                     d_rdata,
  output logic                              d_valid,
  output logic                              err,
  output logic                              stall_f,
  output logic                              stall_m,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [AW-1:0]                     mem_addr,
  output logic [DW-1:0]                     mem_wdata,
  input  logic [DW-1:0]                     mem_rdata,
  input  logic                              mem_ack,
  output logic [1:0]                        dbgState,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] dbgStarveCnt
);

  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t         state;
  logic [SCW-1:0] starveCnt;
  logic [WCW-1:0] waitCnt;
  logic           memReqR;
  logic           memWeR;
  logic [AW-1:0]  memAddrR;
  logic [DW-1:0]  memWdataR;
  logic           ifValidR;
  logic           dValidR;
  logic           errR;
  logic [DW-1:0]  ifRdataR;
  logic [DW-1:0]  dRdataR;

  logic busy;
  logic timedOut;
  logic accDone;
  logic ifCand;
  logic dCand;
  logic grantI;
  logic grantD;

  always_comb begin
    busy     = (state != IDLE);
    // waitCnt counts the ack-less busy cycles already past. The current
    // cycle is the TIMEOUT-th one without an ack when the count is
    // TIMEOUT-1, so mem_req stays high for at most TIMEOUT cycles.
    timedOut = busy && !mem_ack && (waitCnt == WCW'(TIMEOUT - 1));
    accDone  = busy && (mem_ack || timedOut);
    // The requester just served still shows req during its valid cycle,
    // so it cannot take part in the back-to-back grant.
    ifCand   = if_req && (state != BUSY_I);
    dCand    = d_req  && (state != BUSY_D);
    grantI   = 1'b0;
    grantD   = 1'b0;
    if (!busy || accDone) begin
      grantI = ifCand && (!dCand || (starveCnt == SCW'(STARVE_LIMIT)));
      grantD = dCand && !grantI;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      starveCnt <= '0;
      waitCnt   <= '0;
      memReqR   <= 1'b0;
      memWeR    <= 1'b0;
      memAddrR  <= '0;
      memWdataR <= '0;
      ifValidR  <= 1'b0;
      dValidR   <= 1'b0;
      errR      <= 1'b0;
      ifRdataR  <= '0;
      dRdataR   <= '0;
    end else begin
      ifValidR <= 1'b0;
      dValidR  <= 1'b0;
      errR     <= 1'b0;

      if (busy && !accDone) begin
        waitCnt <= waitCnt + 1'b1;
      end

      if (accDone) begin
        errR <= timedOut;
        if (state == BUSY_I) begin
          ifValidR <= 1'b1;
          ifRdataR <= timedOut ? '0 : mem_rdata;
        end else begin
          dValidR <= 1'b1;
          dRdataR <= (timedOut || memWeR) ? '0 : mem_rdata;
        end
      end

      if (grantI) begin
        state     <= BUSY_I;
        memReqR   <= 1'b1;
        memWeR    <= 1'b0;
        memAddrR  <= if_addr;
        memWdataR <= '0;
        waitCnt   <= '0;
        starveCnt <= '0;
      end else if (grantD) begin
        state     <= BUSY_D;
        memReqR   <= 1'b1;
        memWeR    <= d_we;
        memAddrR  <= d_addr;
        memWdataR <= d_wdata;
        waitCnt   <= '0;
        if (if_req && (starveCnt != SCW'(STARVE_LIMIT))) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end else if (accDone) begin
        state   <= IDLE;
        memReqR <= 1'b0;
        memWeR  <= 1'b0;
      end
    end
  end

  assign if_valid     = ifValidR;
  assign if_rdata     = ifRdataR;
  assign d_valid      = dValidR;
  assign d_rdata      = dRdataR;
  assign err          = errR;
  assign stall_f      = if_req & ~ifValidR;
  assign stall_m      = d_req & ~dValidR;
  assign mem_req      = memReqR;
  assign mem_we       = memWeR;
  assign mem_addr     = memAddrR;
  assign mem_wdata    = memWdataR;
  assign dbgState     = state;
  assign dbgStarveCnt = starveCnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter. It runs directed scenarios and then random
//   traffic. A transaction-level model of the arbiter tracks who owns the
//   memory, how long that owner has waited, and which pulses are due. Every
//   cycle, the DUT outputs are compared against that model.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 255;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, d_valid, err, stall_f, stall_m, mem_req, mem_we;
  logic [1:0]    dbgState;
  logic [2:0]    dbgStarveCnt;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbgState(dbgState), .dbgStarveCnt(dbgStarveCnt)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // reference model: owner 0 = nobody, 1 = fetch, 2 = data
  int            owner;
  logic          curWe;
  logic [AW-1:0] curAddr;
  logic [DW-1:0] curWdata;
  int            ackless;
  int            starve;
  logic          eIfValid, eDValid, eErr;
  logic [DW-1:0] eIfRdata, eDRdata;

  task automatic model_reset();
    owner = 0; curWe = 1'b0; curAddr = '0; curWdata = '0;
    ackless = 0; starve = 0;
    eIfValid = 1'b0; eDValid = 1'b0; eErr = 1'b0;
    eIfRdata = '0; eDRdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic          finished, nIf, nD, nErr, wantI, wantD;
    logic [DW-1:0] result;
    int            winner;
    finished = 1'b0; nIf = 1'b0; nD = 1'b0; nErr = 1'b0; result = '0;
    if (owner != 0) begin
      if (mem_ack) begin
        finished = 1'b1;
        result   = curWe ? '0 : mem_rdata;
      end else if (ackless + 1 == TO) begin
        finished = 1'b1;
        nErr     = 1'b1;
      end else begin
        ackless++;
      end
      if (finished) begin
        if (owner == 1) begin nIf = 1'b1; eIfRdata = result; end
        else begin nD = 1'b1; eDRdata = result; end
      end
    end
    if (owner == 0 || finished) begin
      wantI  = if_req && !(finished && owner == 1);
      wantD  = d_req  && !(finished && owner == 2);
      winner = 0;
      if (wantI && wantD) winner = (starve == SL) ? 1 : 2;
      else if (wantD)     winner = 2;
      else if (wantI)     winner = 1;
      if (winner == 1) begin
        starve = 0; curWe = 1'b0; curAddr = if_addr; curWdata = '0;
      end else if (winner == 2) begin
        if (if_req && starve < SL) starve++;
        curWe = d_we; curAddr = d_addr; curWdata = d_wdata;
      end
      owner   = winner;
      ackless = 0;
    end
    eIfValid = nIf; eDValid = nD; eErr = nErr;
  endtask

  task automatic compare_all();
    chk("if_valid", if_valid, eIfValid);
    chk("d_valid",  d_valid,  eDValid);
    chk("err",      err,      eErr);
    if (eIfValid) chk("if_rdata", if_rdata, eIfRdata);
    if (eDValid)  chk("d_rdata",  d_rdata,  eDRdata);
    chk("stall_f", stall_f, if_req & ~eIfValid);
    chk("stall_m", stall_m, d_req & ~eDValid);
    chk("mem_req", mem_req, owner != 0);
    chk("dbgState", dbgState, owner);
    chk("dbgStarveCnt", dbgStarveCnt, starve);
    if (owner != 0) begin
      chk("mem_we",   mem_we,   curWe);
      chk("mem_addr", mem_addr, curAddr);
      if (curWe) chk("mem_wdata", mem_wdata, curWdata);
    end
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic iq, input logic [AW-1:0] ia,
                       input logic dq, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd, input logic ak, input logic [DW-1:0] rd);
    if_req = iq; if_addr = ia;
    d_req = dq; d_we = dw; d_addr = da; d_wdata = dd;
    mem_ack = ak; mem_rdata = rd;
    #1;
    compare_all();
    model_step();
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    chk("rst mem_req",  mem_req,  1'b0);
    chk("rst mem_addr", mem_addr, '0);
    chk("rst d_valid",  d_valid,  1'b0);
    chk("rst state",    dbgState, 2'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // random requesters and memory
  logic          fActive = 1'b0, dActive = 1'b0, dWeR = 1'b0;
  logic [AW-1:0] fAddr = '0, dAddrR = '0;
  logic [DW-1:0] dWdataR = '0;
  int            fRate = 50, dRate = 50, ackMode = 0;

  task automatic auto_cycle();
    logic ak;
    if (eIfValid) fActive = 1'b0;
    if (eDValid)  dActive = 1'b0;
    if (!fActive && $urandom_range(0, 99) < fRate) begin
      fActive = 1'b1; fAddr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dActive && $urandom_range(0, 99) < dRate) begin
      dActive = 1'b1; dWeR = 1'($urandom_range(0, 1));
      dAddrR = $urandom & 32'hFFFF_FFFC; dWdataR = $urandom;
    end
    if (owner != 0) begin
      case (ackMode)
        0:       ak = ($urandom_range(0, 2) == 0);
        1:       ak = 1'b1;
        default: ak = ($urandom_range(0, 299) == 0);
      endcase
    end else begin
      ak = ($urandom_range(0, 15) == 0);
    end
    cycle(fActive, fAddr, dActive, dWeR, dAddrR, dWdataR, ak, $urandom);
  endtask

  initial begin
    int busyCnt, vCnt, bothCnt;
    reset = 1'b0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset mem_req",   mem_req,   1'b0);
    chk("reset mem_we",    mem_we,    1'b0);
    chk("reset mem_addr",  mem_addr,  '0);
    chk("reset mem_wdata", mem_wdata, '0);
    chk("reset if_valid",  if_valid,  1'b0);
    chk("reset d_valid",   d_valid,   1'b0);
    chk("reset if_rdata",  if_rdata,  '0);
    chk("reset d_rdata",   d_rdata,   '0);
    chk("reset err",       err,       1'b0);
    chk("reset starve",    dbgStarveCnt, 3'd0);
    reset = 1'b1;
    @(negedge clk);

    // fetch only
    cycle(1, 32'h100, 0, 0, '0, '0, 0, '0);
    chk("t1 mem_req", mem_req, 1'b1);
    chk("t1 mem_addr", mem_addr, 32'h100);
    chk("t1 stall_f", stall_f, 1'b1);
    cycle(1, 32'h100, 0, 0, '0, '0, 0, '0);
    chk("t1 stall_f wait", stall_f, 1'b1);
    cycle(1, 32'h100, 0, 0, '0, '0, 1, 32'h0050_0093);
    chk("t1 if_valid", if_valid, 1'b1);
    chk("t1 if_rdata", if_rdata, 32'h0050_0093);
    chk("t1 stall_f done", stall_f, 1'b0);
    cycle(0, '0, 0, 0, '0, '0, 0, '0);

    // store and fetch together: data first, fetch back-to-back
    cycle(1, 32'h104, 1, 1, 32'h2000, 32'hDEAD_BEEF, 0, '0);
    chk("t2 mem_we", mem_we, 1'b1);
    chk("t2 mem_addr", mem_addr, 32'h2000);
    chk("t2 mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2 starve", dbgStarveCnt, 3'd1);
    cycle(1, 32'h104, 1, 1, 32'h2000, 32'hDEAD_BEEF, 1, 32'h1234_5678);
    chk("t2 d_valid", d_valid, 1'b1);
    chk("t2 d_rdata", d_rdata, 32'h0);
    chk("t2 fetch mem_addr", mem_addr, 32'h104);
    chk("t2 fetch mem_we", mem_we, 1'b0);
    chk("t2 starve clr", dbgStarveCnt, 3'd0);
    cycle(1, 32'h104, 0, 0, '0, '0, 1, 32'h0060_0113);
    chk("t2 if_rdata", if_rdata, 32'h0060_0113);
    cycle(0, '0, 0, 0, '0, '0, 0, '0);

    // timeout then a late ack
    cycle(0, '0, 1, 0, 32'h3000, '0, 0, '0);
    busyCnt = 0;
    for (int k = 0; k < 300 && !d_valid; k++) begin
      if (mem_req) busyCnt++;
      cycle(0, '0, 1, 0, 32'h3000, '0, 0, $urandom);
    end
    chk("t4 busy cycles", busyCnt, TO);
    chk("t4 d_valid", d_valid, 1'b1);
    chk("t4 err", err, 1'b1);
    chk("t4 d_rdata", d_rdata, 32'h0);
    chk("t4 mem_req", mem_req, 1'b0);
    cycle(0, '0, 0, 0, '0, '0, 1, 32'h5555_5555);
    cycle(0, '0, 0, 0, '0, '0, 1, 32'h5555_5555);
    chk("t4 late d_valid", d_valid, 1'b0);
    chk("t4 late err", err, 1'b0);

    // reset while data access is in flight
    cycle(0, '0, 1, 0, 32'h4000, '0, 0, '0);
    cycle(0, '0, 1, 0, 32'h4000, '0, 0, '0);
    reset_pulse();
    cycle(0, '0, 1, 0, 32'h4000, '0, 0, '0);
    cycle(0, '0, 1, 0, 32'h4000, '0, 1, 32'hCAFE_F00D);
    chk("t5 d_valid", d_valid, 1'b1);
    chk("t5 d_rdata", d_rdata, 32'hCAFE_F00D);
    cycle(0, '0, 0, 0, '0, '0, 0, '0);

    // zero-wait alternating streams: one completion per cycle
    fRate = 100; dRate = 100; ackMode = 1;
    auto_cycle();
    auto_cycle();
    vCnt = 0; bothCnt = 0;
    for (int k = 0; k < 20; k++) begin
      vCnt += int'(if_valid) + int'(d_valid);
      if (if_valid && d_valid) bothCnt++;
      auto_cycle();
    end
    chk("t6 completions", vCnt, 20);
    chk("t6 double valid", bothCnt, 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if (k % 400 == 0) begin
        ackMode = $urandom_range(0, 2);
        fRate   = $urandom_range(20, 100);
        dRate   = $urandom_range(20, 100);
      end
      if ($urandom_range(0, 599) == 0) reset_pulse();
      else auto_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
